// File: rtl/cla_pkg.sv
// Shared constants and the flattened carry-lookahead function
// used both inside a group and across groups.
package cla_pkg;

  localparam int GROUP_DEF = 4;
  localparam int MAX_GRP   = 32;

  // Each carry is an independent sum of products, so no carry waits on another.
  function automatic logic [MAX_GRP:0] cla_carries(
    input logic [MAX_GRP-1:0] p,
    input logic [MAX_GRP-1:0] g,
    input logic               cin
  );
    logic [MAX_GRP:0] c;
    logic             acc;
    logic             prod;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < MAX_GRP; i++) begin
      acc  = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = acc | (prod & cin);
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit combinational carry-lookahead slice with group
// propagate/generate and the carry into its MSB.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = GROUP_DEF
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             p,
  output logic             g,
  output logic             c_msb_in
);

  logic [GROUP-1:0] pb;
  logic [GROUP-1:0] gb;
  logic [MAX_GRP:0] c;
  logic [MAX_GRP:0] c0;
  logic             unused_c;

  assign pb = a ^ b;
  assign gb = a & b;
  assign c  = cla_carries(MAX_GRP'(pb), MAX_GRP'(gb), cin);
  assign c0 = cla_carries(MAX_GRP'(pb), MAX_GRP'(gb), 1'b0);

  assign sum      = pb ^ c[GROUP-1:0];
  assign p        = &pb;
  assign g        = c0[GROUP];
  assign c_msb_in = c[GROUP-1];

  assign unused_c = ^{c, c0};

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-select/lookahead adder-subtractor
// with a valid/ready stream on both sides.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_ovf
);

  localparam int NGRP = WIDTH / GROUP;

  if (WIDTH % GROUP != 0 || WIDTH < GROUP
      || NGRP > MAX_GRP || GROUP > MAX_GRP) begin : g_param_chk
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
  end

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic [NGRP-1:0]  gp;
  logic [NGRP-1:0]  gg;
  logic [NGRP-1:0]  mb0;
  logic [NGRP-1:0]  mb1;

  logic             v1;
  logic             cin1;
  logic [NGRP-1:0]  p1;
  logic [NGRP-1:0]  g1;
  logic [WIDTH-1:0] s0_q;
  logic [WIDTH-1:0] s1_q;
  logic             m0_q;
  logic             m1_q;

  logic             v2;
  logic [MAX_GRP:0] c_all;
  logic [WIDTH-1:0] sel;
  logic             cmsb;
  logic             unused_c;

  assign adv       = !v2 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v2;
  assign bx        = in_sub ? ~in_b : in_b;

  // Each group is evaluated for both carry-in values; stage 2 picks one.
  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    logic [1:0] unused_pg;

    cla_group #(.GROUP(GROUP)) u_c0 (
      .a        (in_a[k*GROUP +: GROUP]),
      .b        (bx[k*GROUP +: GROUP]),
      .cin      (1'b0),
      .sum      (s0[k*GROUP +: GROUP]),
      .p        (gp[k]),
      .g        (gg[k]),
      .c_msb_in (mb0[k])
    );

    cla_group #(.GROUP(GROUP)) u_c1 (
      .a        (in_a[k*GROUP +: GROUP]),
      .b        (bx[k*GROUP +: GROUP]),
      .cin      (1'b1),
      .sum      (s1[k*GROUP +: GROUP]),
      .p        (unused_pg[0]),
      .g        (unused_pg[1]),
      .c_msb_in (mb1[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      cin1 <= 1'b0;
      p1   <= '0;
      g1   <= '0;
      s0_q <= '0;
      s1_q <= '0;
      m0_q <= 1'b0;
      m1_q <= 1'b0;
    end else if (adv) begin
      v1   <= in_valid;
      cin1 <= in_sub;
      p1   <= gp;
      g1   <= gg;
      s0_q <= s0;
      s1_q <= s1;
      m0_q <= mb0[NGRP-1];
      m1_q <= mb1[NGRP-1];
    end
  end

  always_comb begin
    c_all = cla_carries(MAX_GRP'(p1), MAX_GRP'(g1), cin1);
    sel   = '0;
    for (int k = 0; k < NGRP; k++) begin
      sel[k*GROUP +: GROUP] = c_all[k] ? s1_q[k*GROUP +: GROUP]
                                       : s0_q[k*GROUP +: GROUP];
    end
    cmsb = c_all[NGRP-1] ? m1_q : m0_q;
  end

  assign unused_c = ^{c_all, mb0, mb1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2      <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else if (adv) begin
      v2      <= v1;
      out_sum <= {c_all[NGRP], sel};
      out_ovf <= cmsb ^ c_all[NGRP];
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and random checks of pipelined_cla_adder against
// a queue-based arithmetic reference model.
module tb_pipelined_cla_adder;

  localparam int W = 16;

  typedef struct {
    logic [W:0] sum;
    logic       ovf;
    bit         dir;
    logic [W:0] dsum;
    logic       dovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;
  logic         out_ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   beats = 0;
  int   beat_cyc[$];
  exp_t exp_q[$];
  bit   prev_stall = 0;
  logic [W:0] prev_sum;
  logic prev_ovf;
  bit   last_xfer;
  bit   cur_dir = 0;
  logic [W:0] cur_dsum;
  logic cur_dovf;

  pipelined_cla_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic sub);
    exp_t       e;
    logic [W-1:0] bb;
    bb     = sub ? ~b : b;
    e.sum  = (W+1)'(a) + (W+1)'(bb) + (W+1)'(sub);
    e.ovf  = (a[W-1] == bb[W-1]) && (e.sum[W-1] != a[W-1]);
    e.dir  = 0;
    e.dsum = '0;
    e.dovf = 1'b0;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (prev_stall && out_valid) begin
      chk("hold_sum", 32'(out_sum), 32'(prev_sum));
      chk("hold_ovf", 32'(out_ovf), 32'(prev_ovf));
    end
    prev_stall = out_valid && !out_ready;
    prev_sum   = out_sum;
    prev_ovf   = out_ovf;
    if (out_valid && out_ready) begin
      beats++;
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sum", 32'(out_sum), 32'(e.sum));
        chk("ovf", 32'(out_ovf), 32'(e.ovf));
        if (e.dir) begin
          chk("dir_sum", 32'(out_sum), 32'(e.dsum));
          chk("dir_ovf", 32'(out_ovf), 32'(e.dovf));
        end
      end
    end
    last_xfer = in_valid && in_ready && !rst;
    if (last_xfer) begin
      e      = model(in_a, in_b, in_sub);
      e.dir  = cur_dir;
      e.dsum = cur_dsum;
      e.dovf = cur_dovf;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic [W-1:0] a, logic [W-1:0] b, logic sub,
                        bit dir, logic [W:0] dsum, logic dovf);
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    cur_dir  = dir;
    cur_dsum = dsum;
    cur_dovf = dovf;
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic sub,
                      logic [W:0] dsum, logic dovf);
    set_in(a, b, sub, 1, dsum, dovf);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cur_dir  = 0;
  endtask

  task automatic flush();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int b0;
    int sent;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_in('0, '0, 1'b0, 0, '0, 1'b0);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic add with latency
    send(16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
    chk("lat_v_n", 32'(out_valid), 32'd0);
    tick();
    chk("lat_v_n1", 32'(out_valid), 32'd1);
    chk("lat_sum", 32'(out_sum), 32'h05555);
    flush();

    // 2/3: carry chain and subtraction boundaries
    send(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 17'h0FFFE, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 17'h17FFF, 1'b1);
    flush();

    // 4: backpressure on cycles 3..5
    b0   = beats;
    sent = 0;
    set_in(16'($urandom), 16'($urandom), 1'($urandom), 0, '0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      in_valid  = (sent < 4);
      out_ready = !(i >= 3 && i <= 5);
      #1;
      if (i >= 3 && i <= 5) chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      if (last_xfer) begin
        sent++;
        set_in(16'($urandom), 16'($urandom), 1'($urandom), 0, '0, 1'b0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush();
    chk("bp_beats", 32'(beats - b0), 32'd4);

    // 5: asynchronous reset with both stages full
    set_in(16'hAAAA, 16'h5555, 1'b0, 0, '0, 1'b0);
    in_valid = 1'b1;
    tick();
    set_in(16'h1111, 16'h2222, 1'b1, 0, '0, 1'b0);
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(out_sum), 32'd0);
    exp_q.delete();
    prev_stall = 0;
    b0 = beats;
    tick();
    tick();
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    #2 rst = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
    flush();
    chk("post_rst_beats", 32'(beats - b0), 32'd1);

    // 6: 64 back-to-back random operations
    b0 = beats;
    beat_cyc.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      set_in(16'($urandom), 16'($urandom), 1'($urandom), 0, '0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    flush();
    chk("tp_beats", 32'(beats - b0), 32'd64);
    if (beat_cyc.size() == 64)
      chk("tp_span", 32'(beat_cyc[63] - beat_cyc[0]), 32'd63);
    else
      chk("tp_count", 32'(beat_cyc.size()), 32'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
